// File: rtl/ir_pkg.sv
// Shared definitions for the car IR burst link: FSM states, counter widths,
// default burst/gap lengths (common with the transmitter) and the length
// window compare used by the receiver.
package ir_pkg;

    localparam int LEN_W  = 11;
    localparam int TICK_W = 12;

    localparam int START_BURST_SIZE_DEF      = 88;
    localparam int CAR_SELECT_BURST_SIZE_DEF = 22;
    localparam int GAP_SIZE_DEF              = 40;
    localparam int ASSERT_BURST_SIZE_DEF     = 44;
    localparam int DEASSERT_BURST_SIZE_DEF   = 22;
    localparam int TOL_DEF                   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_GAP1   = 3'd2,
        ST_CAR    = 3'd3,
        ST_GAP2   = 3'd4,
        ST_BIT    = 3'd5,
        ST_BITGAP = 3'd6
    } ir_state_e;

    // True when len lies in [nom-tol, nom+tol]; computed one bit wider so
    // neither bound can wrap.
    function automatic logic len_match(input logic [LEN_W-1:0] len,
                                       input logic [LEN_W-1:0] nom,
                                       input logic [LEN_W-1:0] tol);
        logic [LEN_W:0] len_x;
        logic [LEN_W:0] nom_x;
        logic [LEN_W:0] tol_x;
        len_x = {1'b0, len};
        nom_x = {1'b0, nom};
        tol_x = {1'b0, tol};
        return ((len_x + tol_x) >= nom_x) && (len_x <= (nom_x + tol_x));
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// IR input front end: 2-flop synchronizer, sample tick generator and a
// run-length counter. run_done pulses on the tick where the sampled level
// changes; run_level/run_len then describe the run that just finished.
// Between changes run_len is the live length of the current run.
module ir_pulse_timer
    import ir_pkg::*;
#(
    parameter logic [TICK_W-1:0] TICK_MAX = 12'd2499
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ir_in,
    output logic             run_done,
    output logic             run_level,
    output logic [LEN_W-1:0] run_len
);

    logic              sync1_r;
    logic              sync2_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic              tick_s;
    logic              level_r;
    logic [LEN_W-1:0]  run_len_r;

    assign tick_s = (tick_cnt_r == TICK_MAX);

    // Bring the asynchronous IR input into the clock domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= ir_in;
            sync2_r <= sync1_r;
        end
    end

    // Free-running tick divider, wraps at TICK_MAX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + {{(TICK_W-1){1'b0}}, 1'b1};
        end
    end

    // Count equal samples per tick; restart at 1 on a level change, saturate at max.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_r   <= 1'b0;
            run_len_r <= {LEN_W{1'b0}};
        end else if (tick_s && (sync2_r != level_r)) begin
            level_r   <= sync2_r;
            run_len_r <= {{(LEN_W-1){1'b0}}, 1'b1};
        end else if (tick_s && (run_len_r != {LEN_W{1'b1}})) begin
            run_len_r <= run_len_r + {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            run_len_r <= run_len_r;
        end
    end

    assign run_done  = tick_s && (sync2_r != level_r);
    assign run_level = level_r;
    assign run_len   = run_len_r;

endmodule

// File: rtl/ir_receiver.sv
// Car IR burst protocol receiver: validates start / car-select / 4 command
// bit bursts and exposes {NEW,3'b000,COMMAND} as a read-only bus register.
// Optional feature macro IR_RX_ERR_CNT_EN adds an 8-bit saturating error
// counter readable (and write-clearable) at IO_ADDRESS+1.
module ir_receiver
    import ir_pkg::*;
#(
    parameter logic [7:0] IO_ADDRESS            = 8'h94,
    parameter int         IN_MHZ                = 100,
    parameter int         SM_KHZ                = 40,
    parameter int         START_BURST_SIZE      = START_BURST_SIZE_DEF,
    parameter int         CAR_SELECT_BURST_SIZE = CAR_SELECT_BURST_SIZE_DEF,
    parameter int         GAP_SIZE              = GAP_SIZE_DEF,
    parameter int         ASSERT_BURST_SIZE     = ASSERT_BURST_SIZE_DEF,
    parameter int         DEASSERT_BURST_SIZE   = DEASSERT_BURST_SIZE_DEF,
    parameter int         TOL                   = TOL_DEF
)(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IR_IN,
    input  logic       BUS_WE,
    input  logic [7:0] BUS_ADDR,
    output logic [7:0] BUS_DATA_OUT,
    output logic       BUS_DATA_OE,
    output logic [3:0] COMMAND,
    output logic       PACKET_VALID
);

    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(IN_MHZ * 1000 / SM_KHZ - 1);
    localparam logic [LEN_W-1:0]  START_L  = LEN_W'(START_BURST_SIZE);
    localparam logic [LEN_W-1:0]  CAR_L    = LEN_W'(CAR_SELECT_BURST_SIZE);
    localparam logic [LEN_W-1:0]  GAP_L    = LEN_W'(GAP_SIZE);
    localparam logic [LEN_W-1:0]  ONE_L    = LEN_W'(ASSERT_BURST_SIZE);
    localparam logic [LEN_W-1:0]  ZERO_L   = LEN_W'(DEASSERT_BURST_SIZE);
    localparam logic [LEN_W-1:0]  TOL_L    = LEN_W'(TOL);
    localparam logic [LEN_W-1:0]  GAP_TO_L = LEN_W'(GAP_SIZE + TOL + 1);
    localparam logic [7:0]        ERR_ADDR = IO_ADDRESS + 8'd1;

    logic             run_done_s;
    logic             run_level_s;
    logic [LEN_W-1:0] run_len_s;

    ir_state_e        state_r;
    ir_state_e        state_next_s;
    logic             burst_end_s, gap_end_s, gap_to_s, short_s;
    logic             start_ok_s, car_ok_s, gap_ok_s, one_ok_s, zero_ok_s;
    logic             err_s, shift_s, bit_val_s, accept_s;
    logic [1:0]       bit_idx_r;
    logic [3:0]       shift_r;
    logic [3:0]       command_r;
    logic             pv_r, new_r, oe_r;
    logic [7:0]       data_r;
    logic             rd_cmd_s, rd_err_s;
    logic [7:0]       err_cnt_s;

    ir_pulse_timer #(.TICK_MAX(TICK_MAX)) u_timer (
        .clk       (CLK),
        .rst_n     (RESET),
        .ir_in     (IR_IN),
        .run_done  (run_done_s),
        .run_level (run_level_s),
        .run_len   (run_len_s)
    );

    assign burst_end_s = run_done_s && run_level_s;
    assign gap_end_s   = run_done_s && !run_level_s;
    assign gap_to_s    = !run_level_s && (run_len_s >= GAP_TO_L);
    assign short_s     = (run_len_s < TOL_L);
    assign start_ok_s  = len_match(run_len_s, START_L, TOL_L);
    assign car_ok_s    = len_match(run_len_s, CAR_L, TOL_L);
    assign gap_ok_s    = len_match(run_len_s, GAP_L, TOL_L);
    assign one_ok_s    = len_match(run_len_s, ONE_L, TOL_L);
    assign zero_ok_s   = len_match(run_len_s, ZERO_L, TOL_L);

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: advance on each finished run, fall back to IDLE on any mismatch.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:   state_next_s = gap_end_s ? ST_START : ST_IDLE;
            ST_START:  if (burst_end_s) state_next_s = (start_ok_s && !short_s) ? ST_GAP1 : ST_IDLE;
                       else             state_next_s = ST_START;
            ST_GAP1:   if (gap_end_s)   state_next_s = gap_ok_s ? ST_CAR : ST_IDLE;
                       else if (gap_to_s) state_next_s = ST_IDLE;
                       else             state_next_s = ST_GAP1;
            ST_CAR:    if (burst_end_s) state_next_s = car_ok_s ? ST_GAP2 : ST_IDLE;
                       else             state_next_s = ST_CAR;
            ST_GAP2:   if (gap_end_s)   state_next_s = gap_ok_s ? ST_BIT : ST_IDLE;
                       else if (gap_to_s) state_next_s = ST_IDLE;
                       else             state_next_s = ST_GAP2;
            ST_BIT:    if (burst_end_s && (one_ok_s || zero_ok_s))
                           state_next_s = (bit_idx_r == 2'd3) ? ST_IDLE : ST_BITGAP;
                       else if (burst_end_s) state_next_s = ST_IDLE;
                       else             state_next_s = ST_BIT;
            ST_BITGAP: if (gap_end_s)   state_next_s = gap_ok_s ? ST_BIT : ST_IDLE;
                       else if (gap_to_s) state_next_s = ST_IDLE;
                       else             state_next_s = ST_BITGAP;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: protocol errors (short start bursts are noise, not errors) and bit shifts.
    always_comb begin
        err_s     = 1'b0;
        shift_s   = 1'b0;
        bit_val_s = 1'b0;
        case (state_r)
            ST_START:  err_s = burst_end_s && !short_s && !start_ok_s;
            ST_CAR:    err_s = burst_end_s && !car_ok_s;
            ST_GAP1, ST_GAP2, ST_BITGAP:
                       if (gap_end_s) err_s = !gap_ok_s;
                       else           err_s = gap_to_s;
            ST_BIT:    if (burst_end_s && one_ok_s) begin
                           shift_s   = 1'b1;
                           bit_val_s = 1'b1;
                       end else if (burst_end_s && zero_ok_s) begin
                           shift_s   = 1'b1;
                       end else begin
                           err_s     = burst_end_s;
                       end
            default:   err_s = 1'b0;
        endcase
        accept_s = shift_s && (bit_idx_r == 2'd3);
    end

    // Command shift register (LSB first), bit index and accepted command.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            bit_idx_r <= 2'd0;
            shift_r   <= 4'd0;
            command_r <= 4'd0;
            pv_r      <= 1'b0;
        end else begin
            pv_r <= accept_s;
            if (state_r == ST_IDLE) begin
                bit_idx_r <= 2'd0;
            end else if (shift_s) begin
                bit_idx_r <= bit_idx_r + 2'd1;
            end else begin
                bit_idx_r <= bit_idx_r;
            end
            if (err_s) begin
                shift_r <= 4'd0;
            end else if (shift_s) begin
                shift_r[bit_idx_r] <= bit_val_s;
            end else begin
                shift_r <= shift_r;
            end
            if (accept_s) begin
                command_r <= {bit_val_s, shift_r[2:0]};
            end else begin
                command_r <= command_r;
            end
        end
    end

    assign rd_cmd_s = (BUS_ADDR == IO_ADDRESS) && !BUS_WE;

`ifdef IR_RX_ERR_CNT_EN
    logic       wr_err_s;
    logic [7:0] err_cnt_r;

    assign rd_err_s  = (BUS_ADDR == ERR_ADDR) && !BUS_WE;
    assign wr_err_s  = (BUS_ADDR == ERR_ADDR) && BUS_WE;
    assign err_cnt_s = err_cnt_r;

    // Saturating protocol error counter, cleared by a bus write.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            err_cnt_r <= 8'd0;
        end else if (wr_err_s) begin
            err_cnt_r <= 8'd0;
        end else if (err_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end
`else
    assign rd_err_s  = 1'b0;
    assign err_cnt_s = 8'd0;
`endif

    // Registered bus read port and NEW flag (acceptance wins over a read clear).
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            oe_r   <= 1'b0;
            data_r <= 8'd0;
            new_r  <= 1'b0;
        end else begin
            oe_r <= rd_cmd_s || rd_err_s;
            if (rd_cmd_s) begin
                data_r <= {new_r, 3'b000, command_r};
            end else if (rd_err_s) begin
                data_r <= err_cnt_s;
            end else begin
                data_r <= 8'd0;
            end
            if (accept_s) begin
                new_r <= 1'b1;
            end else if (rd_cmd_s) begin
                new_r <= 1'b0;
            end else begin
                new_r <= new_r;
            end
        end
    end

    assign COMMAND      = command_r;
    assign PACKET_VALID = pv_r;
    assign BUS_DATA_OE  = oe_r;
    assign BUS_DATA_OUT = data_r;

endmodule
